// File: rtl/mac_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_pkg: shared FSM encoding and width limits for mult_accumulator. Rev 1.0
// ---------------------------------------------------------------------------
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int         ACC_W_DEFAULT = 12;
  localparam int         ACC_W_MIN     = 8;
  localparam int         ACC_W_MAX     = 16;
  localparam logic [3:0] COUNT_MAX     = 4'd15;

endpackage
`default_nettype wire

// File: rtl/wallace_tree_multiplier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wallace_tree_multiplier: 4x4 unsigned multiply, two 3:2 CSA levels. Rev 1.0
// ---------------------------------------------------------------------------
module wallace_tree_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product
);

  logic [7:0] pp [4];
  logic [7:0] s1, c1, s2, c2;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_pp
      assign pp[i] = {4'b0000, a & {4{b[i]}}} << i;
    end
  endgenerate

  // The true product never exceeds 225, so dropping carries past bit 7 is safe.
  assign s1 = pp[0] ^ pp[1] ^ pp[2];
  assign c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
  assign s2 = s1 ^ c1 ^ pp[3];
  assign c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;

  assign product = s2 + c2;

endmodule
`default_nettype wire

// File: rtl/mult_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_accumulator: sequential multiply-accumulate with clipping sum. Rev 1.0
// ---------------------------------------------------------------------------
module mult_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [3:0]       out_count,
  output logic             out_sat
);

  state_t           state;
  logic [3:0]       a_q, b_q;
  logic             last_q;
  logic [7:0]       prod, prod_q;
  logic [ACC_W-1:0] acc;
  logic [3:0]       count;
  logic             sat;
  logic [ACC_W:0]   sum;

  wallace_tree_multiplier u_mul (
    .a       (a_q),
    .b       (b_q),
    .product (prod)
  );

  // One spare bit exposes overflow so the sum clips instead of wrapping.
  assign sum = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
      prod_q <= '0;
      acc    <= '0;
      count  <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            last_q <= in_last;
            state  <= MUL;
          end
        end
        MUL: begin
          prod_q <= prod;
          state  <= ACC;
        end
        ACC: begin
          if (sum[ACC_W]) begin
            acc <= '1;
            sat <= 1'b1;
          end else begin
            acc <= sum[ACC_W-1:0];
          end
          if (count != COUNT_MAX) count <= count + 4'd1;
          state <= last_q ? OUT : IDLE;
        end
        OUT: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign out_acc   = out_valid ? acc : '0;
  assign out_count = out_valid ? count : '0;
  assign out_sat   = out_valid & sat;

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_accumulator: scoreboard bench driving 12-bit and 8-bit instances. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mult_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [3:0]  a, b;

  logic        ir12, ov12, sat12, ir8, ov8, sat8;
  logic [11:0] acc12;
  logic [7:0]  acc8;
  logic [3:0]  cnt12, cnt8;

  mult_accumulator #(.ACC_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir12),
    .a(a), .b(b), .in_last(in_last), .out_valid(ov12), .out_ready(out_ready),
    .out_acc(acc12), .out_count(cnt12), .out_sat(sat12)
  );

  mult_accumulator #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
    .a(a), .b(b), .in_last(in_last), .out_valid(ov8), .out_ready(out_ready),
    .out_acc(acc8), .out_count(cnt8), .out_sat(sat8)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int cnt;
    int sat;
  } exp_t;

  exp_t q12[$];
  exp_t q8[$];
  int   errors = 0;
  int   checks = 0;
  int   total  = 0;
  int   nterms = 0;
  int   rdy_mode = 0;  // 0 random, 1 held low, 2 held high

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a monotonic running sum clipped once equals clipping at every step.
  task automatic model_term(input int pa, input int pb, input bit last);
    exp_t e;
    total += pa * pb;
    nterms++;
    if (last) begin
      e.acc = (total > 4095) ? 4095 : total;
      e.cnt = (nterms > 15) ? 15 : nterms;
      e.sat = (total > 4095) ? 1 : 0;
      q12.push_back(e);
      e.acc = (total > 255) ? 255 : total;
      e.sat = (total > 255) ? 1 : 0;
      q8.push_back(e);
      total  = 0;
      nterms = 0;
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'($urandom);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on each output handshake and checks output protocol.
  bit          p_ov [2];
  bit          p_or [2];
  logic [31:0] p_acc [2];
  logic [31:0] p_cnt [2];
  logic        p_sat [2];

  task automatic mon(input int idx, input logic ov, input logic ir,
                     input logic [31:0] oacc, input logic [31:0] ocnt, input logic osat);
    string sfx;
    exp_t  e;
    bit    have;
    sfx = (idx == 0) ? "_w12" : "_w8";
    check({"rdy_and_valid", sfx}, {31'd0, ir & ov}, 32'd0);
    if (!ov) check({"idle_outputs_zero", sfx}, oacc | ocnt | {31'd0, osat}, 32'd0);
    if (p_ov[idx] && !p_or[idx]) begin
      check({"hold_valid", sfx}, {31'd0, ov}, 32'd1);
      check({"hold_acc", sfx}, oacc, p_acc[idx]);
      check({"hold_cnt", sfx}, ocnt, p_cnt[idx]);
      check({"hold_sat", sfx}, {31'd0, osat}, {31'd0, p_sat[idx]});
    end
    if (p_ov[idx] && p_or[idx]) begin
      check({"post_hs_valid", sfx}, {31'd0, ov}, 32'd0);
      check({"post_hs_ready", sfx}, {31'd0, ir}, 32'd1);
    end
    if (ov && out_ready) begin
      have = (idx == 0) ? (q12.size() > 0) : (q8.size() > 0);
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result%s: got acc %0d expected no result", sfx, oacc);
      end else begin
        e = (idx == 0) ? q12.pop_front() : q8.pop_front();
        check({"acc", sfx}, oacc, e.acc);
        check({"count", sfx}, ocnt, e.cnt);
        check({"sat", sfx}, {31'd0, osat}, e.sat);
      end
    end
    p_ov[idx]  = ov;
    p_or[idx]  = out_ready;
    p_acc[idx] = oacc;
    p_cnt[idx] = ocnt;
    p_sat[idx] = osat;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ov12, ir12, {20'd0, acc12}, {28'd0, cnt12}, sat12);
      mon(1, ov8, ir8, {24'd0, acc8}, {28'd0, cnt8}, sat8);
    end else begin
      for (int k = 0; k < 2; k++) begin
        p_ov[k] = 1'b0;
        p_or[k] = 1'b0;
      end
    end
  end

  task automatic junk();
    in_valid = 1'($urandom);
    a        = 4'($urandom);
    b        = 4'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Entered and left shortly after a rising edge.
  task automatic send_term(input int ta, input int tb, input bit last);
    int guard = 0;
    while (!ir12) begin
      junk();
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got in_ready 0 expected 1 within 200 cycles");
        return;
      end
    end
    in_valid = 1'b1;
    a        = 4'(ta);
    b        = 4'(tb);
    in_last  = last;
    @(posedge clk); #1;
    model_term(ta, tb, last);
    junk();
    check("mul_ready_low", {31'd0, ir12 | ir8}, 32'd0);
    @(posedge clk); #1;
    junk();
    check("acc_ready_low", {31'd0, ir12 | ir8}, 32'd0);
    check("acc_valid_low", {31'd0, ov12 | ov8}, 32'd0);
    if (last) begin
      @(posedge clk); #1;
      junk();
      check("latency_valid", {31'd0, ov12 & ov8}, 32'd1);
    end
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0;
    while ((q12.size() > 0 || q8.size() > 0) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_q12_empty", q12.size(), 32'd0);
    check("drain_q8_empty", q8.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, ov12 | ov8}, 32'd0);
    check("reset_outputs", {20'd0, acc12} | {24'd0, acc8} | {28'd0, cnt12} | {31'd0, sat12}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", {31'd0, ir12 & ir8}, 32'd1);

    // Single term, then a three-term sum.
    send_term(3, 2, 1);
    send_term(5, 3, 0);
    send_term(9, 5, 0);
    send_term(15, 15, 1);
    // Clipping on the narrow instance, then a fresh sum with the flag cleared.
    send_term(15, 15, 0);
    send_term(15, 15, 1);
    send_term(1, 1, 1);
    drain();

    // Backpressure: result held for five cycles with ignored input pulses.
    rdy_mode = 1;
    send_term(7, 9, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a        = 4'($urandom);
      b        = 4'($urandom);
      check("bp_valid", {31'd0, ov12 & ov8}, 32'd1);
      check("bp_acc", {20'd0, acc12}, 32'd63);
      check("bp_ready_low", {31'd0, ir12 | ir8}, 32'd0);
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_release_ready", {31'd0, ir12 & ir8}, 32'd1);
    rdy_mode = 0;
    send_term(1, 1, 1);
    drain();

    // Reset while accumulating discards the partial sum.
    send_term(6, 4, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midreset_valid", {31'd0, ov12 | ov8}, 32'd0);
    check("midreset_ready", {31'd0, ir12 & ir8}, 32'd1);
    total  = 0;
    nterms = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_term(0, 0, 1);
    drain();

    // Term counter saturates at 15.
    for (int k = 0; k < 17; k++) send_term(1, 1, k == 16);
    drain();

    // Randomized sums.
    for (int s = 0; s < 30; s++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        send_term($urandom_range(0, 15), $urandom_range(0, 15), k == len - 1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
